givens_pair_scheduler: RTL and testbench

- Sequences the shared CORDIC unit to perform one Givens step on a row pair (p, q) of the QR datapath.
- Loads both rows, then issues one vectoring op on column k to zero q[k]. Next it issues rotation ops on columns k+1..N_COL-1, replaying the captured angle, and streams the updated rows out.
- Sits between the matrix-buffer controller and a single CORDIC instance; it is the only driver of that instance's trig, mode and operand inputs.

---
 rtl/givens_pair_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_givens_pair_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/givens_pair_scheduler.sv
`timescale 1ns/1ps
// givens_pair_scheduler
//
// Runs one Givens step on a row pair (p, q) through a shared CORDIC unit.
// Both rows are loaded, one vectoring op on pivot column k zeroes q[k], and
// rotation ops on columns k+1..N_COL-1 replay the captured angle inside the
// CORDIC. The updated rows are then streamed out in load order.
//
// States:
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | waiting for i_start; an illegal pivot column gives o_err
//   S_LOAD     | accepting p[0..N_COL-1] then q[0..N_COL-1]
//   S_VEC_TRIG | one-cycle vectoring trig on column k
//   S_VEC_WAIT | waiting for the vectoring finish (mode held at 1)
//   S_ROT_TRIG | one-cycle rotation trig on column j
//   S_ROT_WAIT | waiting for the rotation finish (mode held at 0)
//   S_DRAIN    | presenting the updated rows, held while stalled
//   S_DONE     | one-cycle o_done, then back to IDLE
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_col_k          job start (IDLE only) and pivot column
//   i_in_valid/o_in_ready     load handshake, data on i_in_data
//   o_out_valid/i_out_ready   result handshake, data on o_out_data
//   o_busy, o_done, o_err     status: not IDLE, job complete, error pulse
//   o_cordic_trig/mode/x/y    CORDIC start, mode (1 = vectoring), operands
//   i_cordic_x/y/finish       CORDIC results and result-valid strobe
//
// All outputs are registered. N_COL must be at least 2.

module givens_pair_scheduler #(
  parameter int N_COL   = 4,
  parameter int COL_W   = 2,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [COL_W-1:0]  i_col_k,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_cordic_trig,
  output logic              o_cordic_mode,
  output logic [DATA_W-1:0] o_cordic_x,
  output logic [DATA_W-1:0] o_cordic_y,
  input  logic [DATA_W-1:0] i_cordic_x,
  input  logic [DATA_W-1:0] i_cordic_y,
  input  logic              i_cordic_finish
);

  localparam int IDX_W = COL_W + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] N_COL_I   = IDX_W'(N_COL);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(2 * N_COL - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(N_COL - 1);
  // Down-counter loaded on trig; it is at TIMEOUT-m on the m-th cycle after
  // the trig, so reaching 1 without a finish puts o_err exactly TIMEOUT
  // cycles after the trig.
  localparam logic [TW-1:0]    WAIT_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VEC_TRIG,
    S_VEC_WAIT,
    S_ROT_TRIG,
    S_ROT_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  // Slots 0..N_COL-1 hold row p, slots N_COL..2*N_COL-1 hold row q.
  logic [DATA_W-1:0] row_buf [2*N_COL];
  logic [COL_W-1:0]  col_k;
  logic [COL_W-1:0]  col_j;
  logic [IDX_W-1:0]  word_cnt;
  logic [TW-1:0]     wait_cnt;

  logic [COL_W-1:0]  k_next;
  logic [COL_W-1:0]  j_next;
  logic [IDX_W-1:0]  p_k_idx;
  logic [IDX_W-1:0]  q_k_idx;
  logic [IDX_W-1:0]  p_j_idx;
  logic [IDX_W-1:0]  q_j_idx;
  logic [IDX_W-1:0]  p_kn_idx;
  logic [IDX_W-1:0]  q_kn_idx;
  logic [IDX_W-1:0]  p_jn_idx;
  logic [IDX_W-1:0]  q_jn_idx;
  logic [IDX_W-1:0]  word_next;

  assign k_next    = col_k + 1'b1;
  assign j_next    = col_j + 1'b1;
  assign p_k_idx   = {1'b0, col_k};
  assign q_k_idx   = {1'b0, col_k} + N_COL_I;
  assign p_j_idx   = {1'b0, col_j};
  assign q_j_idx   = {1'b0, col_j} + N_COL_I;
  assign p_kn_idx  = {1'b0, k_next};
  assign q_kn_idx  = {1'b0, k_next} + N_COL_I;
  assign p_jn_idx  = {1'b0, j_next};
  assign q_jn_idx  = {1'b0, j_next} + N_COL_I;
  assign word_next = word_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      col_k         <= '0;
      col_j         <= '0;
      word_cnt      <= '0;
      wait_cnt      <= '0;
      for (int i = 0; i < 2 * N_COL; i++) row_buf[i] <= '0;
      o_in_ready    <= 1'b0;
      o_out_valid   <= 1'b0;
      o_out_data    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_cordic_trig <= 1'b0;
      o_cordic_mode <= 1'b0;
      o_cordic_x    <= '0;
      o_cordic_y    <= '0;
    end else begin
      o_cordic_trig <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if ({1'b0, i_col_k} >= N_COL_I) begin
              o_err <= 1'b1;
            end else begin
              col_k      <= i_col_k;
              word_cnt   <= '0;
              o_in_ready <= 1'b1;
              o_busy     <= 1'b1;
              state      <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (i_in_valid && o_in_ready) begin
            row_buf[word_cnt] <= i_in_data;
            if (word_cnt == LAST_IDX) begin
              o_in_ready    <= 1'b0;
              o_cordic_trig <= 1'b1;
              o_cordic_mode <= 1'b1;
              o_cordic_x    <= row_buf[p_k_idx];
              // q[N_COL-1] is the word arriving right now, not yet in the buffer.
              o_cordic_y    <= (col_k == LAST_COL) ? i_in_data : row_buf[q_k_idx];
              state         <= S_VEC_TRIG;
            end else begin
              word_cnt <= word_next;
            end
          end
        end

        S_VEC_TRIG: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_VEC_WAIT;
        end

        S_VEC_WAIT: begin
          if (i_cordic_finish) begin
            row_buf[p_k_idx] <= i_cordic_x;
            // The vectoring residue is forced to an exact zero.
            row_buf[q_k_idx] <= '0;
            if (col_k == LAST_COL) begin
              // Slot 0 is not written here since k = N_COL-1 > 0.
              word_cnt    <= '0;
              o_out_valid <= 1'b1;
              o_out_data  <= row_buf[0];
              state       <= S_DRAIN;
            end else begin
              col_j         <= k_next;
              o_cordic_trig <= 1'b1;
              o_cordic_mode <= 1'b0;
              o_cordic_x    <= row_buf[p_kn_idx];
              o_cordic_y    <= row_buf[q_kn_idx];
              state         <= S_ROT_TRIG;
            end
          end else if (wait_cnt == TW'(1)) begin
            o_err         <= 1'b1;
            o_busy        <= 1'b0;
            o_cordic_mode <= 1'b0;
            o_cordic_x    <= '0;
            o_cordic_y    <= '0;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_ROT_TRIG: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_ROT_WAIT;
        end

        S_ROT_WAIT: begin
          if (i_cordic_finish) begin
            row_buf[p_j_idx] <= i_cordic_x;
            row_buf[q_j_idx] <= i_cordic_y;
            if (col_j == LAST_COL) begin
              // Slot 0 is not written here since j = N_COL-1 > 0.
              word_cnt    <= '0;
              o_out_valid <= 1'b1;
              o_out_data  <= row_buf[0];
              state       <= S_DRAIN;
            end else begin
              col_j         <= j_next;
              o_cordic_trig <= 1'b1;
              o_cordic_mode <= 1'b0;
              o_cordic_x    <= row_buf[p_jn_idx];
              o_cordic_y    <= row_buf[q_jn_idx];
              state         <= S_ROT_TRIG;
            end
          end else if (wait_cnt == TW'(1)) begin
            o_err         <= 1'b1;
            o_busy        <= 1'b0;
            o_cordic_mode <= 1'b0;
            o_cordic_x    <= '0;
            o_cordic_y    <= '0;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_DRAIN: begin
          if (o_out_valid && i_out_ready) begin
            if (word_cnt == LAST_IDX) begin
              o_out_valid <= 1'b0;
              o_out_data  <= '0;
              o_done      <= 1'b1;
              state       <= S_DONE;
            end else begin
              word_cnt   <= word_next;
              o_out_data <= row_buf[word_next];
            end
          end
        end

        S_DONE: begin
          o_busy        <= 1'b0;
          o_cordic_mode <= 1'b0;
          o_cordic_x    <= '0;
          o_cordic_y    <= '0;
          state         <= S_IDLE;
        end

        default: begin
          o_busy        <= 1'b0;
          o_in_ready    <= 1'b0;
          o_out_valid   <= 1'b0;
          o_cordic_mode <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_givens_pair_scheduler.sv
`timescale 1ns/1ps
module tb_givens_pair_scheduler;

  localparam int TIMEOUT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_col_k = '0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [11:0] i_in_data = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [11:0] o_out_data;
  logic        o_busy, o_done, o_err;
  logic        o_cordic_trig, o_cordic_mode;
  logic [11:0] o_cordic_x, o_cordic_y;
  logic [11:0] i_cordic_x = '0;
  logic [11:0] i_cordic_y = '0;
  logic        i_cordic_finish = 1'b0;

  // Second instance with N_COL=3 so that an out-of-range pivot fits in i_col_k.
  logic        start3 = 1'b0;
  logic [1:0]  colk3 = '0;
  logic        zero1 = 1'b0;
  logic [11:0] zero12 = '0;
  logic        in_ready3, out_valid3, busy3, done3, err3, trig3, mode3;
  logic [11:0] out_data3, cx3, cy3;

  always #5 i_clk = ~i_clk;

  givens_pair_scheduler #(.N_COL(4), .COL_W(2), .DATA_W(12), .TIMEOUT(TIMEOUT)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_col_k(i_col_k),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cordic_trig(o_cordic_trig), .o_cordic_mode(o_cordic_mode),
    .o_cordic_x(o_cordic_x), .o_cordic_y(o_cordic_y),
    .i_cordic_x(i_cordic_x), .i_cordic_y(i_cordic_y), .i_cordic_finish(i_cordic_finish)
  );

  givens_pair_scheduler #(.N_COL(3), .COL_W(2), .DATA_W(12), .TIMEOUT(TIMEOUT)) u_dut3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start3), .i_col_k(colk3),
    .i_in_valid(zero1), .o_in_ready(in_ready3), .i_in_data(zero12),
    .o_out_valid(out_valid3), .i_out_ready(zero1), .o_out_data(out_data3),
    .o_busy(busy3), .o_done(done3), .o_err(err3),
    .o_cordic_trig(trig3), .o_cordic_mode(mode3),
    .o_cordic_x(cx3), .o_cordic_y(cy3),
    .i_cordic_x(zero12), .i_cordic_y(zero12), .i_cordic_finish(zero1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int words_acc = 0;
  int op_idx = 0;
  int withhold_op = -1;
  int err_delta = -1;
  int trig_cyc = 0;
  bit in_op = 0;
  bit op_mode = 0;
  bit prev_trig = 0;
  bit prev_stall = 0;
  bit hs_seen = 0;
  bit stall_en = 0;
  logic [11:0] prev_data = '0;

  logic [11:0] exp_out[$];
  logic [24:0] exp_trig[$];

  // Load words p[0..3], q[0..3]; expected results; expected trigs {mode, x, y}.
  logic [11:0] w1[8]  = '{12'h100, 12'h010, 12'h020, 12'h030, 12'h100, 12'h040, 12'h050, 12'h060};
  logic [11:0] eo1[8] = '{12'h200, 12'h050, 12'h070, 12'h090, 12'h000, 12'h030, 12'h030, 12'h030};
  logic [24:0] et1[4] = '{{1'b1, 12'h100, 12'h100}, {1'b0, 12'h010, 12'h040},
                          {1'b0, 12'h020, 12'h050}, {1'b0, 12'h030, 12'h060}};
  logic [11:0] w2[8]  = '{12'h111, 12'h222, 12'h333, 12'h044, 12'h0AA, 12'h0BB, 12'h0CC, 12'h011};
  logic [11:0] eo2[8] = '{12'h111, 12'h222, 12'h333, 12'h055, 12'h0AA, 12'h0BB, 12'h0CC, 12'h000};
  logic [24:0] et2[4] = '{{1'b1, 12'h044, 12'h011}, 25'h0, 25'h0, 25'h0};
  logic [11:0] w3[8]  = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h010, 12'h020, 12'h030, 12'h040};
  logic [11:0] eo3[8] = '{12'h001, 12'h022, 12'h033, 12'h044, 12'h010, 12'h000, 12'h02D, 12'h03C};
  logic [24:0] et3[4] = '{{1'b1, 12'h002, 12'h020}, {1'b0, 12'h003, 12'h030},
                          {1'b0, 12'h004, 12'h040}, 25'h0};
  logic [11:0] w4[8]  = '{12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, 12'h00A, 12'h00B, 12'h00C, 12'h00D};
  logic [11:0] eo4[8] = '{12'h0A0, 12'h0B0, 12'h0CC, 12'h0DD, 12'h00A, 12'h00B, 12'h000, 12'hF3D};
  logic [24:0] et4[4] = '{{1'b1, 12'h0C0, 12'h00C}, {1'b0, 12'h0D0, 12'h00D}, 25'h0, 25'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      in_op = 0;
      prev_trig = 0;
      prev_stall = 0;
      hs_seen = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(o_out_valid), 64'(1));
        chk("stall_data", 64'(o_out_data), 64'(prev_data));
      end
      hs_seen = o_out_valid && i_out_ready;
      if (hs_seen) begin
        words_acc++;
        if (exp_out.size() == 0) fail_now("unexpected_out_word");
        else chk("out_word", 64'(o_out_data), 64'(exp_out.pop_front()));
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_data = o_out_data;
      if (o_err) begin
        err_cnt++;
        err_delta = cyc - trig_cyc;
        in_op = 0;
      end
      if (o_cordic_trig) begin
        chk("trig_back_to_back", 64'(prev_trig), 64'(0));
        if (exp_trig.size() == 0) fail_now("unexpected_trig");
        else chk("trig_mode_x_y", 64'({o_cordic_mode, o_cordic_x, o_cordic_y}),
                 64'(exp_trig.pop_front()));
        in_op = 1;
        op_mode = o_cordic_mode;
        trig_cyc = cyc;
      end else if (in_op) begin
        chk("mode_hold_in_wait", 64'(o_cordic_mode), 64'(op_mode));
        if (i_cordic_finish) in_op = 0;
      end
      prev_trig = o_cordic_trig;
      if (o_done) begin
        done_cnt++;
        chk("done_after_words", 64'(words_acc), 64'(8));
        chk("done_out_queue_empty", 64'(exp_out.size()), 64'(0));
      end
    end
  end

  // CORDIC model: 7-cycle finish; x = x+y, y = y-x (rotation) or junk (vectoring).
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge i_clk);
      #1;
      i_cordic_finish = 1'b0;
      if (!i_rst_n) begin
        lat = 0;
      end else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) i_cordic_finish = 1'b1;
        end
        if (o_cordic_trig) begin
          op_idx++;
          if (op_idx != withhold_op) begin
            lat = 7;
            i_cordic_x = o_cordic_x + o_cordic_y;
            i_cordic_y = o_cordic_mode ? 12'h5A5 : (o_cordic_y - o_cordic_x);
          end
        end
      end
    end
  end

  // Result-side ready: optionally low for 5 cycles after each accepted word.
  initial begin
    int stall;
    stall = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!stall_en) begin
        stall = 0;
        i_out_ready = 1'b1;
      end else if (hs_seen) begin
        stall = 5;
        i_out_ready = 1'b0;
      end else if (stall > 0) begin
        stall--;
        i_out_ready = (stall == 0);
      end
    end
  end

  task automatic do_start(input logic [1:0] k);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_col_k = k;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input logic [11:0] w[8]);
    for (int i = 0; i < 8; i++) begin
      int guard;
      guard = 0;
      i_in_valid = 1'b1;
      i_in_data = w[i];
      @(negedge i_clk);
      while (!o_in_ready && guard < 50) begin
        @(negedge i_clk);
        guard++;
      end
      if (!o_in_ready) begin
        fail_now("load_ready_timeout");
        break;
      end
      @(posedge i_clk);
      #1;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [1:0] k, input logic [11:0] w[8],
                         input logic [11:0] eo[8], input logic [24:0] et[4],
                         input int nt, input bit expect_done);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    words_acc = 0;
    if (expect_done) for (int i = 0; i < 8; i++) exp_out.push_back(eo[i]);
    for (int i = 0; i < nt; i++) exp_trig.push_back(et[i]);
    do_start(k);
    feed(w);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 500) fail_now({name, "_completion_timeout"});
    @(negedge i_clk);
    @(negedge i_clk);
    chk({name, "_busy_after"}, 64'(o_busy), 64'(0));
    chk({name, "_done_count"}, 64'(done_cnt - d0), expect_done ? 64'(1) : 64'(0));
    chk({name, "_err_count"}, 64'(err_cnt - e0), expect_done ? 64'(0) : 64'(1));
    chk({name, "_trigs_left"}, 64'(exp_trig.size()), 64'(0));
    chk({name, "_words_left"}, 64'(exp_out.size()), 64'(0));
    if (!expect_done) chk({name, "_timeout_delta"}, 64'(err_delta), 64'(TIMEOUT));
    exp_trig.delete();
    exp_out.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, d0, e0;
    #3 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 64'({o_in_ready, o_out_valid, o_out_data, o_busy, o_done, o_err,
                              o_cordic_trig, o_cordic_mode, o_cordic_x, o_cordic_y}), 64'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_after_reset", 64'({o_busy, o_in_ready, o_cordic_mode}), 64'(0));

    run_job("k0", 2'd0, w1, eo1, et1, 4, 1'b1);
    run_job("k3", 2'd3, w2, eo2, et2, 1, 1'b1);

    stall_en = 1;
    run_job("backpressure", 2'd1, w3, eo3, et3, 3, 1'b1);
    stall_en = 0;

    base = op_idx;
    fork
      run_job("stray_start", 2'd2, w4, eo4, et4, 2, 1'b1);
      begin
        n = 0;
        while (op_idx < base + 2 && n < 500) begin
          @(negedge i_clk);
          n++;
        end
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_col_k = 2'd0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
      end
    join
    repeat (3) @(negedge i_clk);
    chk("stray_start_no_job", 64'(o_busy), 64'(0));

    @(posedge i_clk);
    #1;
    start3 = 1'b1;
    colk3 = 2'd3;
    @(posedge i_clk);
    #1;
    start3 = 1'b0;
    @(negedge i_clk);
    chk("illegal_k_err", 64'(err3), 64'(1));
    chk("illegal_k_busy", 64'(busy3), 64'(0));
    @(negedge i_clk);
    chk("illegal_k_err_pulse", 64'(err3), 64'(0));
    chk("illegal_k_quiet", 64'({busy3, in_ready3, out_valid3, done3, trig3, mode3,
                                out_data3, cx3, cy3}), 64'(0));

    withhold_op = op_idx + 2;
    run_job("timeout", 2'd0, w1, eo1, et1, 2, 1'b0);
    withhold_op = -1;
    run_job("after_timeout", 2'd0, w1, eo1, et1, 4, 1'b1);

    d0 = done_cnt;
    e0 = err_cnt;
    base = op_idx;
    exp_trig.push_back(et4[0]);
    do_start(2'd2);
    feed(w4);
    n = 0;
    while (op_idx == base && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) fail_now("reset_test_no_trig");
    @(negedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({o_in_ready, o_out_valid, o_out_data, o_busy, o_done, o_err,
                                    o_cordic_trig, o_cordic_mode, o_cordic_x, o_cordic_y}), 64'(0));
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("busy_after_abort", 64'(o_busy), 64'(0));
    chk("abort_no_done_err", 64'({done_cnt - d0, err_cnt - e0}), 64'(0));
    chk("abort_trigs_left", 64'(exp_trig.size()), 64'(0));
    exp_trig.delete();
    run_job("k1_after_reset", 2'd1, w3, eo3, et3, 3, 1'b1);

    repeat (3) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
